wb_bridge_arbiter: RTL and testbench
====================================

# wb_bridge_arbiter

Round-robin arbiter that shares one Wishbone-to-FTA bridge port among NMST Wishbone masters. It sits directly in front of the bridge, grants one master per bus cycle and holds the grant until that master drops cyc. It inserts the idle gap the bridge needs between cycles so the bridge detects each new cycle, and it adds a response timeout so a lost FTA response cannot hang a master.

## Interface
- NMST, 4: number of masters (2..8).
- WID, 256: data width; select width is WID/8.
- TMO, 64: cycles from grant to bridge ack or err before timeout (≥4).
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- m_cyc_i  in  NMST  per-master cycle.
- m_stb_i  in  NMST  per-master strobe.
- m_we_i  in  NMST  per-master write enable.
- m_sel_i  in  NMST*WID/8  per-master byte selects; slice i = master i.
- m_adr_i  in  NMST*32  per-master address.
- m_dat_i  in  NMST*WID  per-master write data.
- m_ack_o  out  NMST  per-master acknowledge.
- m_err_o  out  NMST*3  per-master error code; fta_bus_pkg encoding.
- m_dat_o  out  NMST*WID  per-master read data.
- s_cs_o, s_cyc_o, s_stb_o, s_we_o  out  1 each  to bridge.
- s_sel_o  out  WID/8  to bridge.
- s_adr_o  out  32  to bridge.
- s_dat_o  out  WID  to bridge.
- s_ack_i  in  1  from bridge.
- s_err_i  in  3  from bridge.
- s_dat_i  in  WID  from bridge.
- gnt_o  out  NMST  one-hot current grant, for debug.

## Operation
- States are IDLE, BUSY, TOUT and GAP. Grant index gnt and last-grant index lst are registered.
- IDLE: if any m_cyc_i is set, select the first requester searching from lst+1 with wrap-around. Load gnt and lst, clear the timeout counter and go to BUSY. With no requester, remain in IDLE.
- BUSY: s_* outputs mirror master gnt's inputs. s_cs_o equals s_cyc_o.
  - m_ack_o[gnt], m_err_o[gnt] and m_dat_o[gnt] mirror s_ack_i, s_err_i and s_dat_i.
  - All other masters see ack=0, err=OKAY and dat=0.
  - The counter increments every cycle while s_ack_i is 0.
- BUSY exits:
  - If m_cyc_i[gnt] falls, go to GAP.
  - Otherwise, if the counter reaches TMO-1 with s_ack_i still 0, go to TOUT.
- TOUT: s_cyc_o=0. Master gnt sees ack=1, err=ERR and dat=0. When m_cyc_i[gnt] falls, go to GAP.
- GAP: all s_* outputs are 0 and all master outputs are 0. Leave for IDLE once s_ack_i is 0. GAP lasts at least one cycle.
- The grant is never preempted while the granted master holds cyc, including when other masters request.
- Fairness: after a grant to master i, master i is the lowest-priority requester in the next arbitration.

## Timing
- Reset: state=IDLE, lst=NMST-1 so master 0 wins the first arbitration. gnt_o=0, all s_* outputs 0, all m_ack_o and m_dat_o 0, all m_err_o OKAY.
- Grant latency:
  - A request sampled in IDLE at edge k makes s_cyc_o high after edge k.
  - The bridge registers the FTA request at edge k+1.
- Response path (m_ack_o, m_err_o, m_dat_o in BUSY) is combinational from the bridge outputs, with no added latency.
- Back-to-back grant spacing:
  - The master drops cyc at edge n and the arbiter enters GAP at edge n+1.
  - IDLE follows no earlier than edge n+2 and the new grant arrives no earlier than edge n+3.
  - s_cyc_o is therefore low for at least two cycles.
- Simultaneous events:
  - If cyc drops in the same cycle as the timeout, go to GAP and raise no error.
  - If s_ack_i rises in the same cycle as the timeout, the ack wins and the arbiter stays in BUSY.
- Abandoned cycle: if the master drops cyc before ack, go to GAP. A late s_ack_i holds GAP until it clears and is never forwarded.
- Reset mid-cycle: asynchronous clear to the reset values, with no response to any master.
- Counter: $clog2(TMO)+1 bits, saturating. No wrap-around is possible.

## Structure
- Add to fta_bus_pkg: arb_state_t enum {IDLE, BUSY, TOUT, GAP}. The error codes come from the existing fta_bus_pkg OKAY and ERR.
- Sub-module rr_pick: NMST requests plus last index → next index and valid, purely combinational. It is reusable by other arbiters.
- The arbiter FSM, counter, muxes and response demux live in wb_bridge_arbiter itself.

## Test plan
- Single master 2 read, adr 0x1000: s_cyc_o rises one cycle after m_cyc_i[2]. s_ack_i and s_dat_i=0xAA.. are forwarded the same cycle to master 2 only. m_ack_o[0,1,3] stay 0.
- Masters 0, 1 and 3 all request continuously from reset: grants follow the order 0, 1, 3, 0. s_cyc_o is low for ≥2 cycles between grants.
- Master 1 is granted, master 0 requests mid-cycle: master 1 keeps the grant until it drops cyc, then master 0 is granted.
- Bridge never acks, TMO=64: at cycle 64 after grant, m_ack_o[g]=1 and m_err_o[g]=ERR. After the master drops cyc, the arbiter passes through GAP to IDLE.
- Master drops cyc before ack, bridge acks one cycle later: no master sees ack, GAP holds until s_ack_i=0, and the next request is granted normally.
- rst_ni pulsed low while in BUSY: all outputs reach their reset values immediately. After release, the next arbitration favours master 0.

Source files
------------

// File: rtl/fta_bus_pkg.sv
// -----------------------------------------------------------------------------
// fta_bus_pkg
// Shared FTA bus definitions: the 3-bit response error codes returned to
// masters and the state type of the Wishbone bridge arbiter.
// Ports: none (package).
// -----------------------------------------------------------------------------
package fta_bus_pkg;

   // Response error codes carried on the 3-bit err fields
   typedef enum logic [2:0] {
      OKAY    = 3'd0,
      DECERR  = 3'd1,
      PROTERR = 3'd2,
      ERR     = 3'd3
   } fta_err_t;

   // Wishbone bridge arbiter states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      TOUT = 2'd2,
      GAP  = 2'd3
   } arb_state_t;

   localparam int ADR_W = 32;
   localparam int ERR_W = 3;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Starting one past the last-granted
// index and wrapping around, it returns the first asserted request.
// Ports:
//   req  in  NMST  request vector
//   lst  in  IW    index granted last time (lowest priority now)
//   idx  out IW    index of the selected requester
//   vld  out 1     at least one request is asserted
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int NMST = 4,
   parameter int IW   = (NMST > 1) ? $clog2(NMST) : 1
)(
   input  logic [NMST-1:0] req,
   input  logic [IW-1:0]   lst,
   output logic [IW-1:0]   idx,
   output logic            vld
);

   logic [IW-1:0] cand;

   // Walk the candidates lst+1, lst+2, ... with explicit wrap at NMST-1 so
   // non-power-of-two master counts never index past the request vector.
   always_comb begin
      cand = lst;
      idx  = '0;
      vld  = 1'b0;
      for (int k = 0; k < NMST; k++) begin
         cand = (cand == IW'(NMST - 1)) ? '0 : cand + 1'b1;
         if (!vld && req[cand]) begin
            vld = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/wb_bridge_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bridge_arbiter
// Round-robin arbiter sharing one Wishbone-to-FTA bridge port among NMST
// Wishbone masters. A grant is held until the master drops cyc, an idle gap
// is inserted between bus cycles, and a response timeout answers the master
// with ERR if the bridge never acknowledges.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i     per-master Wishbone controls (NMST each)
//   m_sel_i/m_adr_i/m_dat_i    per-master select/address/write data, slice i
//   m_ack_o/m_err_o/m_dat_o    per-master response (err is 3 bits/master)
//   s_cs_o .. s_dat_o          request towards the bridge
//   s_ack_i/s_err_i/s_dat_i    response from the bridge
//   gnt_o                      one-hot current grant (debug)
// -----------------------------------------------------------------------------
module wb_bridge_arbiter
   import fta_bus_pkg::*;
#(
   parameter int NMST = 4,
   parameter int WID  = 256,
   parameter int TMO  = 64
)(
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NMST-1:0]           m_cyc_i,
   input  logic [NMST-1:0]           m_stb_i,
   input  logic [NMST-1:0]           m_we_i,
   input  logic [NMST*(WID/8)-1:0]   m_sel_i,
   input  logic [NMST*ADR_W-1:0]     m_adr_i,
   input  logic [NMST*WID-1:0]       m_dat_i,
   output logic [NMST-1:0]           m_ack_o,
   output logic [NMST*ERR_W-1:0]     m_err_o,
   output logic [NMST*WID-1:0]       m_dat_o,
   output logic                      s_cs_o,
   output logic                      s_cyc_o,
   output logic                      s_stb_o,
   output logic                      s_we_o,
   output logic [WID/8-1:0]          s_sel_o,
   output logic [ADR_W-1:0]          s_adr_o,
   output logic [WID-1:0]            s_dat_o,
   input  logic                      s_ack_i,
   input  logic [ERR_W-1:0]          s_err_i,
   input  logic [WID-1:0]            s_dat_i,
   output logic [NMST-1:0]           gnt_o
);

   localparam int SW = WID / 8;
   localparam int IW = (NMST > 1) ? $clog2(NMST) : 1;
   localparam int CW = $clog2(TMO) + 1;

   arb_state_t      state;
   logic [IW-1:0]   gnt;
   logic [IW-1:0]   lst;
   logic [CW-1:0]   cnt;

   logic [IW-1:0]   pick_idx;
   logic            pick_vld;

   logic            cur_cyc;
   logic            cur_stb;
   logic            cur_we;
   logic [SW-1:0]   cur_sel;
   logic [ADR_W-1:0] cur_adr;
   logic [WID-1:0]  cur_dat;

   rr_pick #(
      .NMST (NMST),
      .IW   (IW)
   ) u_pick (
      .req  (m_cyc_i),
      .lst  (lst),
      .idx  (pick_idx),
      .vld  (pick_vld)
   );

   // Request mux: the granted master's bus fields, used both by the FSM
   // (to see cyc fall) and as the bridge-side request in BUSY.
   always_comb begin
      cur_cyc = 1'b0;
      cur_stb = 1'b0;
      cur_we  = 1'b0;
      cur_sel = '0;
      cur_adr = '0;
      cur_dat = '0;
      for (int i = 0; i < NMST; i++) begin
         if (gnt == IW'(i)) begin
            cur_cyc = m_cyc_i[i];
            cur_stb = m_stb_i[i];
            cur_we  = m_we_i[i];
            cur_sel = m_sel_i[i*SW +: SW];
            cur_adr = m_adr_i[i*ADR_W +: ADR_W];
            cur_dat = m_dat_i[i*WID +: WID];
         end
      end
   end

   // Arbitration FSM. The counter only advances while the bridge is silent
   // and stops on TMO-1, so a simultaneous ack keeps the cycle alive and a
   // simultaneous cyc drop takes the GAP path before any error is raised.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         gnt   <= '0;
         lst   <= IW'(NMST - 1);
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  gnt   <= pick_idx;
                  lst   <= pick_idx;
                  cnt   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (!cur_cyc) begin
                  state <= GAP;
               end else if (!s_ack_i) begin
                  if (cnt == CW'(TMO - 1)) begin
                     state <= TOUT;
                  end else if (cnt != '1) begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            TOUT: begin
               if (!cur_cyc) begin
                  state <= GAP;
               end
            end
            GAP: begin
               // A late ack from an abandoned cycle must drain first
               if (!s_ack_i) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bridge request and per-master response demux. Responses are passed
   // straight through in BUSY; TOUT fabricates an ERR ack for the owner.
   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_adr_o = '0;
      s_dat_o = '0;
      m_ack_o = '0;
      m_dat_o = '0;
      gnt_o   = '0;
      for (int i = 0; i < NMST; i++) begin
         m_err_o[i*ERR_W +: ERR_W] = OKAY;
      end
      case (state)
         BUSY: begin
            s_cyc_o = cur_cyc;
            s_stb_o = cur_stb;
            s_we_o  = cur_we;
            s_sel_o = cur_sel;
            s_adr_o = cur_adr;
            s_dat_o = cur_dat;
            for (int i = 0; i < NMST; i++) begin
               if (gnt == IW'(i)) begin
                  gnt_o[i]                  = 1'b1;
                  m_ack_o[i]                = s_ack_i;
                  m_err_o[i*ERR_W +: ERR_W] = s_err_i;
                  m_dat_o[i*WID +: WID]     = s_dat_i;
               end
            end
         end
         TOUT: begin
            for (int i = 0; i < NMST; i++) begin
               if (gnt == IW'(i)) begin
                  gnt_o[i]                  = 1'b1;
                  m_ack_o[i]                = 1'b1;
                  m_err_o[i*ERR_W +: ERR_W] = ERR;
               end
            end
         end
         default: begin
         end
      endcase
      s_cs_o = s_cyc_o;
   end

endmodule

// File: tb/tb_wb_bridge_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_bridge_arbiter
// Directed bench for wb_bridge_arbiter with a behavioural reference model
// that is compared against every DUT output on each falling clock edge.
// -----------------------------------------------------------------------------
module tb_wb_bridge_arbiter;
   import fta_bus_pkg::*;

   localparam int NMST = 4;
   localparam int WID  = 256;
   localparam int TMO  = 64;
   localparam int SW   = WID / 8;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   always #5 clk = ~clk;

   logic [NMST-1:0]      mCyc = '0, mStb = '0, mWe = '0;
   logic [NMST*SW-1:0]   mSel = '0;
   logic [NMST*32-1:0]   mAdr = '0;
   logic [NMST*WID-1:0]  mDatIn = '0;
   logic [NMST-1:0]      mAck;
   logic [NMST*3-1:0]    mErr;
   logic [NMST*WID-1:0]  mDatOut;
   logic                 sCs, sCyc, sStb, sWe;
   logic [SW-1:0]        sSel;
   logic [31:0]          sAdr;
   logic [WID-1:0]       sDatOut;
   logic                 sAck = 1'b0;
   logic [2:0]           sErr = 3'd0;
   logic [WID-1:0]       sDatIn = '0;
   logic [NMST-1:0]      gnt;

   wb_bridge_arbiter #(.NMST(NMST), .WID(WID), .TMO(TMO)) dut (
      .clk_i(clk), .rst_ni(rstN),
      .m_cyc_i(mCyc), .m_stb_i(mStb), .m_we_i(mWe), .m_sel_i(mSel),
      .m_adr_i(mAdr), .m_dat_i(mDatIn),
      .m_ack_o(mAck), .m_err_o(mErr), .m_dat_o(mDatOut),
      .s_cs_o(sCs), .s_cyc_o(sCyc), .s_stb_o(sStb), .s_we_o(sWe),
      .s_sel_o(sSel), .s_adr_o(sAdr), .s_dat_o(sDatOut),
      .s_ack_i(sAck), .s_err_i(sErr), .s_dat_i(sDatIn),
      .gnt_o(gnt)
   );

   int checks = 0;
   int passes = 0;

   // Reference model: phase 0 = bus free, 1 = owner being served,
   // 2 = owner timed out, 3 = waiting for the bridge to go quiet
   int phase = 0;
   int owner = 0;
   int lastOwner = NMST - 1;
   int waitCount = 0;

   task automatic checkOutput(input string name, input logic [WID-1:0] got,
                              input logic [WID-1:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
   endtask

   task automatic compareAll();
      logic [NMST-1:0] expGnt;
      logic [3:0]      expCtl;
      logic [SW-1:0]   expSel;
      logic [31:0]     expAdr;
      logic [WID-1:0]  expDat;
      logic            expAck;
      logic [2:0]      expErr;
      logic [WID-1:0]  expRd;
      expGnt = '0; expCtl = '0; expSel = '0; expAdr = '0; expDat = '0;
      if (phase == 1) begin
         expCtl = {mCyc[owner], mCyc[owner], mStb[owner], mWe[owner]};
         expSel = mSel[owner*SW +: SW];
         expAdr = mAdr[owner*32 +: 32];
         expDat = mDatIn[owner*WID +: WID];
      end
      if (phase == 1 || phase == 2) expGnt[owner] = 1'b1;
      checkOutput("gnt", gnt, expGnt);
      checkOutput("sctl", {sCs, sCyc, sStb, sWe}, expCtl);
      checkOutput("ssel", sSel, expSel);
      checkOutput("sadr", sAdr, expAdr);
      checkOutput("sdat", sDatOut, expDat);
      for (int i = 0; i < NMST; i++) begin
         expAck = 1'b0; expErr = 3'd0; expRd = '0;
         if (i == owner && phase == 1) begin
            expAck = sAck; expErr = sErr; expRd = sDatIn;
         end else if (i == owner && phase == 2) begin
            expAck = 1'b1; expErr = 3'd3;
         end
         checkOutput($sformatf("ack%0d", i), mAck[i], expAck);
         checkOutput($sformatf("err%0d", i), mErr[i*3 +: 3], expErr);
         checkOutput($sformatf("dat%0d", i), mDatOut[i*WID +: WID], expRd);
      end
   endtask

   // Inputs only change just after a rising edge, so the values seen here
   // are exactly the ones the next rising edge will sample.
   task automatic modelStep();
      bit found;
      case (phase)
         0: begin
            found = 0;
            for (int k = 1; k <= NMST; k++) begin
               int c;
               c = (lastOwner + k) % NMST;
               if (!found && mCyc[c]) begin
                  found = 1; owner = c; lastOwner = c; waitCount = 0; phase = 1;
               end
            end
         end
         1: begin
            if (!mCyc[owner]) phase = 3;
            else if (!sAck) begin
               waitCount++;
               if (waitCount >= TMO) phase = 2;
            end
         end
         2: if (!mCyc[owner]) phase = 3;
         default: if (!sAck) phase = 0;
      endcase
   endtask

   always @(negedge clk) begin
      if (!rstN) begin
         phase = 0; owner = 0; lastOwner = NMST - 1; waitCount = 0;
      end
      compareAll();
      if (rstN) modelStep();
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input int m, input logic cyc, input logic we,
                                input logic [31:0] adr, input logic [WID-1:0] dat);
      mCyc[m] = cyc;
      mStb[m] = cyc;
      mWe[m]  = we;
      mAdr[m*32 +: 32]    = adr;
      mDatIn[m*WID +: WID] = dat;
      mSel[m*SW +: SW]    = {(SW/4){4'(m + 1)}};
   endtask

   task automatic waitGrant(input int m, input int limit, input string name);
      for (int c = 0; c < limit && !gnt[m]; c++) tick(1);
      checkOutput(name, gnt, NMST'(1) << m);
   endtask

   task automatic ackAndRelease(input int m);
      sAck = 1'b1;
      tick(1);
      sAck = 1'b0;
      applyStimulus(m, 0, 0, 32'h0, '0);
   endtask

   function automatic logic [WID-1:0] pattern(input int m);
      return {(WID/32){32'hC0DE_0000 + 32'(m)}};
   endfunction

   int order[4];
   int lowCount;
   int who;

   initial begin
      tick(3);
      rstN = 1'b1;
      checkOutput("rst gnt", gnt, '0);
      tick(1);

      // Single master 2 read at 0x1000
      applyStimulus(2, 1, 0, 32'h1000, pattern(2));
      #1 checkOutput("t1 pre", sCyc, 1'b0);
      tick(1);
      checkOutput("t1 cyc", sCyc, 1'b1);
      checkOutput("t1 adr", sAdr, 32'h1000);
      tick(1);
      sAck = 1'b1; sDatIn = {32{8'hAA}}; sErr = 3'd2;
      #1;
      checkOutput("t1 ack", mAck, 4'b0100);
      checkOutput("t1 err", mErr[6 +: 3], 3'd2);
      checkOutput("t1 dat", mDatOut[2*WID +: WID], {32{8'hAA}});
      tick(1);
      sAck = 1'b0; sDatIn = '0; sErr = 3'd0;
      applyStimulus(2, 0, 0, 32'h0, '0);
      tick(4);

      // Masters 0, 1 and 3 request continuously from reset
      rstN = 1'b0;
      tick(2);
      rstN = 1'b1;
      applyStimulus(0, 1, 0, 32'h2000, pattern(0));
      applyStimulus(1, 1, 1, 32'h2100, pattern(1));
      applyStimulus(3, 1, 0, 32'h2300, pattern(3));
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 10 && gnt == '0; c++) tick(1);
         who = 0;
         for (int i = NMST - 1; i >= 0; i--) if (gnt[i]) who = i;
         order[r] = who;
         ackAndRelease(who);
         #1 lowCount = sCyc ? 0 : 1;
         tick(1);
         applyStimulus(who, 1, who == 1, 32'h2000 + 32'(who) * 32'h100, pattern(who));
         if (r < 3) begin
            for (int c = 0; c < 10 && gnt == '0; c++) begin
               if (!sCyc) lowCount++;
               tick(1);
            end
            checkOutput($sformatf("t2 gap%0d", r), lowCount >= 2, 1'b1);
         end
      end
      checkOutput("t2 order", {8'(order[0]), 8'(order[1]), 8'(order[2]), 8'(order[3])},
                  32'h00010300);
      for (int i = 0; i < NMST; i++) applyStimulus(i, 0, 0, 32'h0, '0);
      tick(4);

      // Master 1 holds its grant while master 0 requests
      applyStimulus(1, 1, 1, 32'h3100, pattern(1));
      waitGrant(1, 5, "t3 g1");
      applyStimulus(0, 1, 0, 32'h3000, pattern(0));
      tick(5);
      checkOutput("t3 hold", gnt, 4'b0010);
      ackAndRelease(1);
      waitGrant(0, 8, "t3 g0");
      ackAndRelease(0);
      tick(4);

      // Bridge never answers: timeout after TMO cycles
      applyStimulus(3, 1, 0, 32'h4300, pattern(3));
      waitGrant(3, 5, "t4 g3");
      tick(63);
      checkOutput("t4 early", mAck, 4'b0000);
      tick(1);
      checkOutput("t4 ack", mAck, 4'b1000);
      checkOutput("t4 err", mErr[9 +: 3], ERR);
      applyStimulus(3, 0, 0, 32'h0, '0);
      tick(1);
      checkOutput("t4 gap", gnt, 4'b0000);
      tick(3);

      // Abandoned cycle with a late ack from the bridge
      applyStimulus(0, 1, 0, 32'h5000, pattern(0));
      waitGrant(0, 5, "t5 g0");
      tick(2);
      applyStimulus(0, 0, 0, 32'h0, '0);
      tick(1);
      sAck = 1'b1; sDatIn = {32{8'h55}};
      #1 checkOutput("t5 late", mAck, 4'b0000);
      applyStimulus(1, 1, 0, 32'h5100, pattern(1));
      tick(2);
      checkOutput("t5 hold", gnt, 4'b0000);
      sAck = 1'b0; sDatIn = '0;
      waitGrant(1, 6, "t5 g1");
      ackAndRelease(1);
      tick(3);

      // Reset pulsed while a cycle is in progress
      applyStimulus(2, 1, 1, 32'h6200, pattern(2));
      waitGrant(2, 5, "t6 g2");
      #2 rstN = 1'b0;
      #1;
      checkOutput("t6 cyc", sCyc, 1'b0);
      checkOutput("t6 gnt", gnt, 4'b0000);
      checkOutput("t6 ack", mAck, 4'b0000);
      tick(2);
      applyStimulus(0, 1, 0, 32'h6000, pattern(0));
      rstN = 1'b1;
      waitGrant(0, 5, "t6 g0");
      ackAndRelease(0);
      applyStimulus(2, 0, 0, 32'h0, '0);
      tick(4);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

endmodule
